// File: rtl/conv3x3_window_gen.sv
// 3x3 sliding-window generator for the Conv2D datapath.
// Holds the two previous image rows in circular line memories, shifts a
// 3x3 tap array on every accepted pixel and flags a window once it sits
// fully inside the frame. One pixel per cycle, no backpressure.

// One window row: three taps shifting from the newest column (c2) toward
// the oldest (c0) on every accepted beat.
module conv3x3_win_row #(
  parameter int WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_shift,
  input  logic [WIDTH-1:0]      i_data,
  output logic [2:0][WIDTH-1:0] o_taps
);

  logic [2:0][WIDTH-1:0] r_taps;

  // Shift c2->c1->c0 and load the new pixel into c2.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_taps <= '0;
    end else if (i_shift) begin
      r_taps[0] <= r_taps[1];
      r_taps[1] <= r_taps[2];
      r_taps[2] <= i_data;
    end
  end

  assign o_taps = r_taps;

endmodule

module conv3x3_window_gen #(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 1024,
  parameter int WIDTH      = 8
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_valid,
  output logic [9*WIDTH-1:0] o_win,
  output logic               o_eof
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  // Raster position of the next beat.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Effective position of the current beat: sof forces (0,0).
  logic          w_sof;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;

  // Line memories: mid holds the previous row, top the one before it.
  logic [WIDTH-1:0] r_mid [0:IMG_WIDTH-1];
  logic [WIDTH-1:0] r_top [0:IMG_WIDTH-1];
  logic [WIDTH-1:0] w_m;
  logic [WIDTH-1:0] w_t;

  // Window taps, [row][col], row 0 oldest, col 2 newest.
  logic [2:0][WIDTH-1:0]      w_row_in;
  logic [2:0][2:0][WIDTH-1:0] w_taps;

  logic w_hit;
  logic w_last;
  logic r_valid;
  logic r_eof;

  assign w_sof = i_valid & i_sof;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;

  // Raster advance with row and frame wrap from the effective position.
  always_comb begin
    w_col_nxt = w_col + COL_ONE;
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : (w_row + ROW_ONE);
    end
  end

  // Position counters move only on accepted beats.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Asynchronous read of both rows at the current column; the write below
  // lands on the same address, so the read sees the pre-write contents.
  assign w_t = r_top[w_col];
  assign w_m = r_mid[w_col];

  // Row delay: mid ages into top, the incoming pixel becomes mid. No reset,
  // so the arrays map onto RAM; stale contents are never windowed.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      r_top[w_col] <= w_m;
      r_mid[w_col] <= i_data;
    end
  end

  assign w_row_in[0] = w_t;
  assign w_row_in[1] = w_m;
  assign w_row_in[2] = i_data;

  genvar gr, gc;
  generate
    for (gr = 0; gr < 3; gr++) begin : g_row
      conv3x3_win_row #(.WIDTH(WIDTH)) u_row (
        .i_clk   (i_clk),
        .i_resetn(i_resetn),
        .i_shift (i_valid),
        .i_data  (w_row_in[gr]),
        .o_taps  (w_taps[gr])
      );
      for (gc = 0; gc < 3; gc++) begin : g_col
        assign o_win[WIDTH*(3*gr+gc) +: WIDTH] = w_taps[gr][gc];
      end
    end
  endgenerate

  // A window is complete once two full rows and two columns precede it.
  assign w_hit  = i_valid && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
  assign w_last = i_valid && (w_row == ROW_LAST) && (w_col == COL_LAST);

  // Registered window strobe and end-of-frame marker, one-cycle pulses.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_valid <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= w_hit;
      r_eof   <= w_last;
    end
  end

  assign o_valid = r_valid;
  assign o_eof   = r_eof;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Randomized self-checking bench for conv3x3_window_gen: a 4x4 and a 5x3
// instance driven from a pixel-image reference model.
module tb_conv3x3_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v   [2];
  logic        sof [2];
  logic [7:0]  d   [2];
  logic        ov  [2];
  logic        oe  [2];
  logic [71:0] ow  [2];

  conv3x3_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .WIDTH(8)) u_dut0 (
    .i_clk(clk), .i_resetn(rst_n), .i_valid(v[0]), .i_sof(sof[0]),
    .i_data(d[0]), .o_valid(ov[0]), .o_win(ow[0]), .o_eof(oe[0])
  );

  conv3x3_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .WIDTH(8)) u_dut1 (
    .i_clk(clk), .i_resetn(rst_n), .i_valid(v[1]), .i_sof(sof[1]),
    .i_data(d[1]), .o_valid(ov[1]), .o_win(ow[1]), .o_eof(oe[1])
  );

  typedef struct {
    logic [71:0] win;
    bit          eof;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [71:0] obs0[$];
  logic [71:0] obs1[$];

  int W[2] = '{4, 5};
  int H[2] = '{4, 3};
  int mr[2];
  int mc[2];
  int img[2][4][5];
  bit pend[2];
  bit expv[2];
  int nwin[2];
  int neof[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: store the pixel in a frame image, window it from the image.
  task automatic beat(input int u, input int data, input bit s);
    exp_t e;
    bit   hit;
    if (s) begin
      mr[u] = 0;
      mc[u] = 0;
    end
    img[u][mr[u]][mc[u]] = data;
    hit = (mr[u] >= 2) && (mc[u] >= 2);
    if (hit) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[8*(3*r+c) +: 8] = 8'(img[u][mr[u]-2+r][mc[u]-2+c]);
      e.eof = (mr[u] == H[u]-1) && (mc[u] == W[u]-1);
      if (u == 0) q0.push_back(e); else q1.push_back(e);
    end
    mc[u]++;
    if (mc[u] == W[u]) begin
      mc[u] = 0;
      mr[u]++;
      if (mr[u] == H[u]) mr[u] = 0;
    end
    v[u]    = 1'b1;
    sof[u]  = s;
    d[u]    = 8'(data);
    pend[u] = hit;
    @(posedge clk); #1;
    v[u]    = 1'b0;
    sof[u]  = 1'b0;
    pend[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int u, input int base, input bit s, input bit gaps);
    for (int r = 0; r < H[u]; r++)
      for (int c = 0; c < W[u]; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
        beat(u, base + r*W[u] + c + 1, s && (r == 0) && (c == 0));
      end
  endtask

  task automatic start();
    for (int u = 0; u < 2; u++) begin
      nwin[u] = 0;
      neof[u] = 0;
    end
    obs0.delete();
    obs1.delete();
  endtask

  task automatic finish_scn(input string tag, input int u, input int wins, input int eofs);
    idle(3);
    chk({tag, "_nwin"}, nwin[u], wins);
    chk({tag, "_neof"}, neof[u], eofs);
    chk({tag, "_qleft"}, (u == 0) ? q0.size() : q1.size(), 0);
  endtask

  // Expected strobe for the cycle: an accepted beat that completes a window.
  always @(posedge clk) begin
    expv[0] = v[0] && pend[0];
    expv[1] = v[1] && pend[1];
  end

  task automatic mon(input int u);
    exp_t e;
    chk("o_valid", ov[u], expv[u]);
    if (!ov[u]) chk("eof_no_valid", oe[u], 1'b0);
    if (ov[u]) begin
      nwin[u]++;
      if (oe[u]) neof[u]++;
      if (u == 0) obs0.push_back(ow[0]); else obs1.push_back(ow[1]);
      if (((u == 0) ? q0.size() : q1.size()) == 0) begin
        chk("extra_window", ov[u], 1'b0);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk("win", ow[u], e.win);
        chk("eof", oe[u], e.eof);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      v[u] = 1'b0; sof[u] = 1'b0; d[u] = '0; pend[u] = 1'b0; expv[u] = 1'b0;
      mr[u] = 0; mc[u] = 0;
    end
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_valid", ov[u], 1'b0);
      chk("rst_eof", oe[u], 1'b0);
      chk("rst_win", ow[u], 72'h0);
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic frame, back-to-back.
    start();
    frame(0, 0, 1'b1, 1'b0);
    finish_scn("basic", 0, 4, 1);
    if (obs0.size() == 4) begin
      chk("basic_first", obs0[0], 72'h0B0A09070605030201);
      chk("basic_last",  obs0[3], 72'h100F0E0C0B0A080706);
    end else chk("basic_obs", obs0.size(), 4);

    // Same frame with random idle gaps.
    start();
    frame(0, 0, 1'b1, 1'b1);
    finish_scn("gaps", 0, 4, 1);
    if (obs0.size() == 4) begin
      chk("gaps_first", obs0[0], 72'h0B0A09070605030201);
      chk("gaps_last",  obs0[3], 72'h100F0E0C0B0A080706);
    end else chk("gaps_obs", obs0.size(), 4);

    // Two frames back-to-back, second without sof.
    start();
    frame(0, 0, 1'b1, 1'b0);
    frame(0, 100, 1'b0, 1'b0);
    finish_scn("two", 0, 8, 2);
    if (obs0.size() == 8) chk("two_fifth", obs0[4], 72'h6F6E6D6B6A69676665);
    else chk("two_obs", obs0.size(), 8);

    // sof mid-frame: frame 1 abandoned after 6 beats.
    start();
    for (int i = 0; i < 6; i++) beat(0, i + 1, i == 0);
    frame(0, 50, 1'b1, 1'b1);
    finish_scn("midsof", 0, 4, 1);

    // Asynchronous reset mid-frame, then a frame without sof.
    start();
    for (int i = 0; i < 9; i++) beat(0, 200 + i, i == 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov[0], 1'b0);
    chk("arst_eof", oe[0], 1'b0);
    chk("arst_win", ow[0], 72'h0);
    for (int u = 0; u < 2; u++) begin
      mr[u] = 0;
      mc[u] = 0;
    end
    q0.delete();
    q1.delete();
    #3 rst_n = 1'b1;
    idle(1);
    frame(0, 30, 1'b0, 1'b1);
    finish_scn("arst", 0, 4, 1);

    // 5x3 geometry: centres at (1,1), (1,2), (1,3) -> pixels 7, 8, 9.
    start();
    frame(1, 0, 1'b1, 1'b0);
    finish_scn("w5h3", 1, 3, 1);
    if (obs1.size() == 3) begin
      chk("w5h3_c0", obs1[0][39:32], 8'd7);
      chk("w5h3_c1", obs1[1][39:32], 8'd8);
      chk("w5h3_c2", obs1[2][39:32], 8'd9);
    end else chk("w5h3_obs", obs1.size(), 3);

    // Random pixel values on the 4x4 instance.
    start();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat(0, int'($urandom_range(0, 255)), (f == 0) && (i == 0));
      end
    finish_scn("rand", 0, 12, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
